// File: rtl/pcs_pkg.sv
// rtl/pcs_pkg.sv - shared 10GBASE-R PCS widths, sync headers and lock FSM states
package pcs_pkg;
   localparam int DATA_W  = 64;
   localparam int HEAD_W  = 2;
   localparam int BLOCK_W = 66;
   localparam int RES_MAX = 65;
   localparam int RES_W   = 7;

   localparam logic [HEAD_W-1:0] SYNC_DATA = 2'b10;
   localparam logic [HEAD_W-1:0] SYNC_CTRL = 2'b01;

   typedef enum logic [1:0] {
      UNLOCK = 2'd0,
      LOCK   = 2'd1,
      SLIP   = 2'd2
   } lock_state_e;

   function automatic logic head_valid(input logic [HEAD_W-1:0] head);
      return (head == SYNC_DATA) || (head == SYNC_CTRL);
   endfunction
endpackage

// File: rtl/block_lock_rx.sv
// rtl/block_lock_rx.sv - block lock FSM: hunts for sync header alignment by requesting bit slips
module block_lock_rx
   import pcs_pkg::*;
#(
   parameter int LOCK_CNT  = 64,
   parameter int INVLD_MAX = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid,
   input  logic [HEAD_W-1:0] head,
   output logic              slip,
   output logic              lock
);
   localparam int CNT_W = $clog2(LOCK_CNT + 1);
   localparam int INV_W = $clog2(INVLD_MAX + 1);

   lock_state_e      state_q;
   logic [CNT_W-1:0] blk_q;
   logic [INV_W-1:0] inv_q;
   logic             slip_q;
   logic             lock_q;
   logic             hv;

   assign hv   = head_valid(head);
   assign slip = slip_q;
   assign lock = lock_q;

   // slip_q is raised on entry to SLIP, so it is high for exactly the one cycle spent there
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= UNLOCK;
         blk_q   <= '0;
         inv_q   <= '0;
         slip_q  <= 1'b0;
         lock_q  <= 1'b0;
      end else begin
         slip_q <= 1'b0;
         case (state_q)
            UNLOCK: begin
               if (valid) begin
                  if (!hv) begin
                     state_q <= SLIP;
                     slip_q  <= 1'b1;
                     blk_q   <= '0;
                  end else if (blk_q == CNT_W'(LOCK_CNT - 1)) begin
                     state_q <= LOCK;
                     lock_q  <= 1'b1;
                     blk_q   <= '0;
                     inv_q   <= '0;
                  end else begin
                     blk_q <= blk_q + 1'b1;
                  end
               end
            end
            LOCK: begin
               if (valid) begin
                  if (!hv && inv_q == INV_W'(INVLD_MAX - 1)) begin
                     state_q <= SLIP;
                     slip_q  <= 1'b1;
                     lock_q  <= 1'b0;
                     blk_q   <= '0;
                     inv_q   <= '0;
                  end else if (blk_q == CNT_W'(LOCK_CNT - 1)) begin
                     blk_q <= '0;
                     inv_q <= '0;
                  end else begin
                     blk_q <= blk_q + 1'b1;
                     if (!hv) inv_q <= inv_q + 1'b1;
                  end
               end
            end
            SLIP: begin
               state_q <= UNLOCK;
               blk_q   <= '0;
               inv_q   <= '0;
            end
            default: begin
               state_q <= UNLOCK;
               blk_q   <= '0;
               inv_q   <= '0;
            end
         endcase
      end
   end
endmodule

// File: rtl/gearbox_rx.sv
// rtl/gearbox_rx.sv - 64b->66b receive gearbox with bit slip; GEARBOX_RX_LOCK_EN adds internal block lock
module gearbox_rx
   import pcs_pkg::*;
#(
   parameter int LOCK_CNT  = 64,
   parameter int INVLD_MAX = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_i,
   input  logic              slip_i,
   output logic              valid_o,
   output logic [HEAD_W-1:0] head_o,
   output logic [DATA_W-1:0] data_o,
   output logic              lock_v_o
);
   localparam int COMB_W = RES_MAX + DATA_W;

   logic [RES_MAX-1:0] buf_q, buf_d;
   logic [RES_W-1:0]   res_q, res_d;
   logic               valid_q, valid_d;
   logic [HEAD_W-1:0]  head_q, head_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic               slip;

   logic [RES_MAX-1:0] kept;
   logic [RES_W-1:0]   kept_n;
   logic [DATA_W-1:0]  word;
   logic               drop_first;
   logic [7:0]         avail;
   logic [COMB_W-1:0]  comb, comb_sh;

`ifdef GEARBOX_RX_LOCK_EN
   logic lock;
   logic unused_slip_i;

   assign unused_slip_i = slip_i;
   assign lock_v_o      = lock;

   block_lock_rx #(
      .LOCK_CNT (LOCK_CNT),
      .INVLD_MAX(INVLD_MAX)
   ) u_lock (
      .clk  (clk),
      .reset(reset),
      .valid(valid_q),
      .head (head_q),
      .slip (slip),
      .lock (lock)
   );
`else
   assign slip     = slip_i;
   assign lock_v_o = 1'b0;
`endif

   // Residue bits sit at buf_q[res_q-1:0] with bit 0 oldest; everything above is kept zero
   always_comb begin
      kept       = buf_q;
      kept_n     = res_q;
      word       = data_i;
      drop_first = 1'b0;
      if (slip) begin
         if (res_q == '0) begin
            word       = data_i >> 1;
            drop_first = 1'b1;
         end else begin
            kept   = buf_q >> 1;
            kept_n = res_q - 1'b1;
         end
      end
      avail   = 8'(kept_n) + (drop_first ? 8'd63 : 8'd64);
      comb    = {{DATA_W{1'b0}}, kept} | ({{RES_MAX{1'b0}}, word} << kept_n);
      comb_sh = comb >> BLOCK_W;

      valid_d = 1'b0;
      head_d  = head_q;
      data_d  = data_q;
      buf_d   = comb[RES_MAX-1:0];
      res_d   = avail[RES_W-1:0];
      if (avail >= 8'(BLOCK_W)) begin
         valid_d = 1'b1;
         head_d  = comb[HEAD_W-1:0];
         data_d  = comb[BLOCK_W-1:HEAD_W];
         buf_d   = comb_sh[RES_MAX-1:0];
         res_d   = 7'(avail - 8'(BLOCK_W));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_q   <= '0;
         res_q   <= '0;
         valid_q <= 1'b0;
         head_q  <= '0;
         data_q  <= '0;
      end else begin
         buf_q   <= buf_d;
         res_q   <= res_d;
         valid_q <= valid_d;
         head_q  <= head_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign head_o  = head_q;
   assign data_o  = data_q;

   res_bound_a: assert property (@(posedge clk) disable iff (reset) res_q <= 7'(RES_MAX));
endmodule

// File: tb/tb_gearbox_rx.sv
// tb/tb_gearbox_rx.sv - randomized scoreboard bench for gearbox_rx against a bit-queue reference
module tb_gearbox_rx;
   import pcs_pkg::*;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [DATA_W-1:0] data_i = '0;
   logic              slip_i = 1'b0;
   logic              valid_o;
   logic [HEAD_W-1:0] head_o;
   logic [DATA_W-1:0] data_o;
   logic              lock_v_o;

   always #5 clk = ~clk;

   gearbox_rx dut (
      .clk     (clk),
      .reset   (reset),
      .data_i  (data_i),
      .slip_i  (slip_i),
      .valid_o (valid_o),
      .head_o  (head_o),
      .data_o  (data_o),
      .lock_v_o(lock_v_o)
   );

   int n_chk  = 0;
   int n_fail = 0;

   bit             tx_bits[$];
   bit             pend[$];
   bit             exp_v_q[$];
   logic [65:0]    exp_b_q[$];
   logic [65:0]    last_b = '0;
   bit             mon_en = 1'b1;
   bit             ev;
   logic [65:0]    eb;

   task automatic check(input string nm, input logic [65:0] act, input logic [65:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: the receiver sees one bit stream; slips delete its oldest bit, blocks are successive 66-bit chunks
   task automatic model_step(input logic [63:0] w, input bit slp);
      logic [65:0] b;
      int first;
      first = 0;
      if (slp) begin
         if (pend.size() == 0) first = 1;
         else void'(pend.pop_front());
      end
      for (int i = first; i < 64; i++) pend.push_back(w[i]);
      if (pend.size() >= 66) begin
         for (int i = 0; i < 66; i++) b[i] = pend.pop_front();
         exp_v_q.push_back(1'b1);
         exp_b_q.push_back(b);
      end else begin
         exp_v_q.push_back(1'b0);
      end
   endtask

   task automatic gen_blocks(input int n, input int mode);
      logic [65:0] b;
      for (int k = 0; k < n; k++) begin
         b[65:34] = $urandom;
         b[33:2]  = $urandom;
         case (mode)
            0:       b[1:0] = SYNC_CTRL;
            1:       b[1:0] = $urandom_range(0, 1) ? SYNC_DATA : SYNC_CTRL;
            default: b[1:0] = 2'b00;
         endcase
         for (int i = 0; i < 66; i++) tx_bits.push_back(b[i]);
      end
   endtask

   task automatic drive(input bit slp);
      logic [63:0] w;
      for (int i = 0; i < 64; i++) w[i] = (tx_bits.size() > 0) ? tx_bits.pop_front() : 1'($urandom);
      data_i = w;
      slip_i = slp;
      @(posedge clk);
      model_step(w, slp);
      #1;
      slip_i = 1'b0;
   endtask

   task automatic drain();
      while (tx_bits.size() >= 64) drive(1'b0);
   endtask

   task automatic do_reset();
      #2 reset = 1'b1;
      #1;
      check("rst_valid", valid_o, 0);
      check("rst_head", head_o, 0);
      check("rst_data", data_o, 0);
      check("rst_lock", lock_v_o, 0);
      exp_v_q.delete();
      exp_b_q.delete();
      pend.delete();
      tx_bits.delete();
      last_b = '0;
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!reset && mon_en && exp_v_q.size() > 0) begin
         ev = exp_v_q.pop_front();
         check("valid", valid_o, ev);
         if (ev) begin
            eb = exp_b_q.pop_front();
            check("block", {data_o, head_o}, eb);
            last_b = eb;
         end else begin
            check("hold", {data_o, head_o}, last_b);
         end
      end
   end

   initial begin
      int res0_seen;
      bit low_seen;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("init_valid", valid_o, 0);
      check("init_head", head_o, 0);
      check("init_data", data_o, 0);
      check("init_lock", lock_v_o, 0);
      reset = 1'b0;

`ifndef GEARBOX_RX_LOCK_EN
      // aligned stream: 3 periods of 32 blocks in 33 words
      gen_blocks(96, 0);
      drain();

      // reset mid-stream, then first-block latency
      gen_blocks(10, 1);
      repeat (5) drive(1'b0);
      do_reset();
      gen_blocks(4, 1);
      drain();

      // three junk bits removed by three consecutive slips
      do_reset();
      for (int i = 0; i < 3; i++) tx_bits.push_back(1'($urandom));
      gen_blocks(64, 1);
      drive(1'b1);
      drive(1'b1);
      drive(1'b1);
      drain();

      // slip while the residue is empty drops data_i[0]
      do_reset();
      gen_blocks(80, 1);
      res0_seen = 0;
      while (tx_bits.size() >= 64) begin
         if (pend.size() == 0) res0_seen++;
         drive(pend.size() == 0 && res0_seen == 2);
      end

      // long random stream with sparse random slips
      do_reset();
      gen_blocks(300, 1);
      while (tx_bits.size() >= 64) drive($urandom_range(0, 15) == 0);

      // loopback of 2000 random blocks
      do_reset();
      gen_blocks(2000, 1);
      drain();
      drive(1'b0);
      #10;
      check("queue_empty", 66'(exp_v_q.size()), 0);
      check("lock_tied", lock_v_o, 0);
`else
      mon_en = 1'b0;
      for (int i = 0; i < 7; i++) tx_bits.push_back(1'($urandom));
      gen_blocks(400, 1);
      while (tx_bits.size() >= 64) drive(1'($urandom));
      check("lock_acq", lock_v_o, 1);

      gen_blocks(15, 2);
      gen_blocks(100, 1);
      low_seen = 1'b0;
      while (tx_bits.size() >= 64) begin
         drive(1'b0);
         if (!lock_v_o) low_seen = 1'b1;
      end
      check("lock_hold_15", low_seen, 0);

      gen_blocks(40, 2);
      gen_blocks(20, 1);
      low_seen = 1'b0;
      while (tx_bits.size() >= 64) begin
         drive(1'b0);
         if (!lock_v_o) low_seen = 1'b1;
      end
      check("lock_lost", low_seen, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
